sa_array: RTL and testbench

Parametrised output-stationary systolic array computing a ROWS×COLS outer-product accumulation, C[r][c] = Σk A[k][r]·B[k][c], over a streamed job of K beats. It is the next-generation compute core of the SA datapath and replaces the fixed 4×8 PE grid. It adds a valid/ready input stream, internal operand skewing, job framing and a row-serial result drain with backpressure.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_pe.sv | 62 ++++++
 rtl/sa_array.sv | 177 +++++++++++++++++
 tb/tb_sa_array.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and constants for the sa_array systolic core.
package sa_pkg;

    localparam int SA_ROWS = 4;
    localparam int SA_COLS = 8;
    localparam int SA_DW   = 8;
    localparam int SA_AW   = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } sa_state_e;

    // Index width that never collapses to zero bits.
    function automatic int sa_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary PE: forwards a right and b down, accumulates a*b.
// Operand signedness follows the SA_SIGNED_EN macro.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW = SA_DW,
    parameter int AW = SA_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] a_in,
    input  logic          a_valid_in,
    input  logic          a_first_in,
    input  logic [DW-1:0] b_in,
    input  logic          b_valid_in,
    input  logic          b_first_in,
    output logic [DW-1:0] a_out,
    output logic          a_valid_out,
    output logic          a_first_out,
    output logic [DW-1:0] b_out,
    output logic          b_valid_out,
    output logic          b_first_out,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] prod_ext;

`ifdef SA_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    assign prod     = (2*DW)'($signed(a_in)) * (2*DW)'($signed(b_in));
    assign prod_ext = AW'(prod);
`else
    logic [2*DW-1:0] prod;
    assign prod     = (2*DW)'(a_in) * (2*DW)'(b_in);
    assign prod_ext = AW'(prod);
`endif

    // NOTE: state uses non-blocking assignments so every PE samples its
    // neighbours' pre-edge values, which is what makes the array systolic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            a_first_out <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
            b_first_out <= 1'b0;
            acc         <= '0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            a_first_out <= a_first_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
            b_first_out <= b_first_in;
            if (a_valid_in) begin
                acc <= a_first_in ? prod_ext : acc + prod_ext;
            end
        end
    end

endmodule

// File: rtl/sa_array.sv
// ROWS x COLS output-stationary systolic array with streamed input and
// row-serial drain. Build option: SA_SIGNED_EN (signed operands).
module sa_array
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int DW   = SA_DW,
    parameter int AW   = SA_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ROWS*DW-1:0]        a_data,
    input  logic [COLS*DW-1:0]        b_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [COLS*AW-1:0]        out_data,
    output logic [sa_width(ROWS)-1:0] out_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy
);

    localparam int RW = sa_width(ROWS);
    localparam int CW = sa_width(ROWS + COLS);
    localparam int LW = DW + 2;   // {valid, first, data}
    localparam logic [CW-1:0] FLUSH_LAST = CW'(ROWS + COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    sa_state_e       state;
    logic [CW-1:0]   flush_cnt;
    logic            accept;
    logic [ROWS*DW-1:0] a_q;
    logic [COLS*DW-1:0] b_q;
    logic            beat_valid;
    logic            beat_first;

    logic [LW-1:0]   a_h [ROWS][COLS+1];
    logic [LW-1:0]   b_v [ROWS+1][COLS];
    logic [AW-1:0]   acc [ROWS][COLS];
    logic            unused_edge;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            beat_valid <= 1'b0;
            beat_first <= 1'b0;
        end else begin
            beat_valid <= accept;
            beat_first <= accept && (state == ST_IDLE);
            if (accept) begin
                a_q <= a_data;
                b_q <= b_data;
            end
        end
    end

    // Skew: row r sees its a element r cycles late, column c its b element c late.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [LW-1:0] a_word;
        assign a_word = {beat_valid, beat_first, a_q[r*DW +: DW]};
        if (r == 0) begin : g_direct
            assign a_h[r][0] = a_word;
        end else begin : g_dly
            logic [LW-1:0] dly [r];
            // NOTE: the delay lines are reset in full, data included, so a
            // reset mid-job leaves no stale beats in flight.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < r; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= a_word;
                    for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
                end
            end
            assign a_h[r][0] = dly[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [LW-1:0] b_word;
        assign b_word = {beat_valid, beat_first, b_q[c*DW +: DW]};
        if (c == 0) begin : g_direct
            assign b_v[0][c] = b_word;
        end else begin : g_dly
            logic [LW-1:0] dly [c];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < c; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= b_word;
                    for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
                end
            end
            assign b_v[0][c] = dly[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk         (clk),
                .reset       (reset),
                .a_in        (a_h[r][c][DW-1:0]),
                .a_valid_in  (a_h[r][c][LW-1]),
                .a_first_in  (a_h[r][c][DW]),
                .b_in        (b_v[r][c][DW-1:0]),
                .b_valid_in  (b_v[r][c][LW-1]),
                .b_first_in  (b_v[r][c][DW]),
                .a_out       (a_h[r][c+1][DW-1:0]),
                .a_valid_out (a_h[r][c+1][LW-1]),
                .a_first_out (a_h[r][c+1][DW]),
                .b_out       (b_v[r+1][c][DW-1:0]),
                .b_valid_out (b_v[r+1][c][LW-1]),
                .b_first_out (b_v[r+1][c][DW]),
                .acc         (acc[r][c])
            );
        end
    end

    // Operands leaving the right and bottom edges have no consumer.
    always_comb begin
        unused_edge = 1'b0;
        for (int r = 0; r < ROWS; r++) unused_edge = unused_edge ^ (^a_h[r][COLS]);
        for (int c = 0; c < COLS; c++) unused_edge = unused_edge ^ (^b_v[ROWS][c]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            out_row   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    flush_cnt <= '0;
                    state     <= in_last ? ST_FLUSH : ST_FEED;
                end
                ST_FEED: if (accept && in_last) begin
                    flush_cnt <= '0;
                    state     <= ST_FLUSH;
                end
                // Last PE settles ROWS+COLS-1 edges after in_last; drain opens one edge later.
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) state <= ST_DRAIN;
                    else flush_cnt <= flush_cnt + CW'(1);
                end
                ST_DRAIN: if (out_ready) begin
                    if (out_row == ROW_LAST) begin
                        out_row <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        out_row <= out_row + RW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = !reset && ((state == ST_IDLE) || (state == ST_FEED));
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (out_row == ROW_LAST);
    assign busy      = (state != ST_IDLE);

    // NOTE: out_data gets a default before the loop so no latch is inferred.
    always_comb begin
        out_data = '0;
        for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc[out_row][c];
    end

endmodule

// File: tb/tb_sa_array.sv
// Directed self-checking bench for sa_array at default geometry.
module tb_sa_array;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 24;
    localparam int RW   = 2;
    localparam int OW   = COLS * AW;

    logic               clk;
    logic               reset;
    logic [ROWS*DW-1:0] a_data;
    logic [COLS*DW-1:0] b_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [OW-1:0]      out_data;
    logic [RW-1:0]      out_row;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;

    sa_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_data    (a_data),
        .b_data    (b_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] av [ROWS];
    logic [DW-1:0] bv [COLS];
    logic [AW-1:0] exp_m [ROWS][COLS];

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic last, output int acc_edge);
        int n;
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = av[r];
        for (int c = 0; c < COLS; c++) b_data[c*DW +: DW] = bv[c];
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        acc_edge = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int acc_edge, input int lat);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        if (lat >= 0) check({tag, "_latency"}, cyc - acc_edge, lat);
    endtask

    task automatic drain(input string tag, input int stall_row, input int stall_n);
        logic [OW-1:0] e;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) e[c*AW +: AW] = exp_m[r][c];
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    check($sformatf("%s_stall_row", tag), out_row, r);
                    check($sformatf("%s_stall_data", tag), out_data, e);
                    check($sformatf("%s_stall_in_ready", tag), in_ready, 0);
                end
            end
            check($sformatf("%s_row%0d_idx", tag, r), out_row, r);
            check($sformatf("%s_row%0d_valid", tag, r), out_valid, 1);
            check($sformatf("%s_row%0d_last", tag, r), out_last, r == ROWS - 1);
            check($sformatf("%s_row%0d_data", tag, r), out_data, e);
            check($sformatf("%s_row%0d_in_ready", tag, r), in_ready, 0);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        logic [AW-1:0] sgn_exp;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        a_data    = '0;
        b_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single beat: a=1, b=c+1.
        for (int r = 0; r < ROWS; r++) av[r] = 8'd1;
        for (int c = 0; c < COLS; c++) bv[c] = DW'(c + 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = AW'(c + 1);
        send_beat(1'b1, e);
        wait_out("single", e, 12);
        drain("single", -1, 0);

        // K=3 back-to-back, a=r+1, b=2 -> 6(r+1).
        for (int r = 0; r < ROWS; r++) av[r] = DW'(r + 1);
        for (int c = 0; c < COLS; c++) bv[c] = 8'd2;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = AW'(6 * (r + 1));
        for (int k = 0; k < 3; k++) send_beat(k == 2, e);
        wait_out("k3", e, 12);
        drain("k3", -1, 0);

        // K=4 with two idle cycles between beats -> 8(r+1).
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = AW'(8 * (r + 1));
        for (int k = 0; k < 4; k++) begin
            send_beat(k == 3, e);
            if (k < 3) begin
                repeat (2) begin
                    @(posedge clk); #1;
                    check("gap_in_ready", in_ready, 1);
                end
            end
        end
        wait_out("k4gap", e, 12);
        drain("k4gap", -1, 0);

        // Backpressure at row 1 for 5 cycles.
        for (int r = 0; r < ROWS; r++) av[r] = 8'd1;
        for (int c = 0; c < COLS; c++) bv[c] = DW'(c + 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = AW'(c + 1);
        send_beat(1'b1, e);
        wait_out("bp", e, 12);
        drain("bp", 1, 5);

        // 0xFF * 0x02, twice.
`ifdef SA_SIGNED_EN
        sgn_exp = 24'hFFFFFE;
`else
        sgn_exp = 24'h0001FE;
`endif
        for (int r = 0; r < ROWS; r++) av[r] = 8'hFF;
        for (int c = 0; c < COLS; c++) bv[c] = 8'h02;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = sgn_exp;
        for (int t = 0; t < 2; t++) begin
            send_beat(1'b1, e);
            wait_out($sformatf("sign%0d", t), e, 12);
            drain($sformatf("sign%0d", t), -1, 0);
        end

        // 2^16 beats of 0xFF*0xFF: sum wraps to 0x010000 either way.
        for (int c = 0; c < COLS; c++) bv[c] = 8'hFF;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = 24'h010000;
        for (int k = 0; k < 65536; k++) send_beat(k == 65535, e);
        wait_out("wrap", e, 12);
        drain("wrap", -1, 0);

        // Reset in the middle of FLUSH.
        for (int r = 0; r < ROWS; r++) av[r] = DW'(r + 1);
        for (int c = 0; c < COLS; c++) bv[c] = DW'(c + 1);
        send_beat(1'b1, e);
        repeat (3) @(posedge clk);
        #1;
        check("flush_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("midrst_out_valid_hold", out_valid, 0);
        check("midrst_acc_clear", out_data, 0);
        reset = 1'b0;
        #1;
        check("postrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        for (int r = 0; r < ROWS; r++) av[r] = DW'(r + 2);
        for (int c = 0; c < COLS; c++) bv[c] = 8'd1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_m[r][c] = AW'(r + 2);
        send_beat(1'b1, e);
        wait_out("fresh", e, 12);
        drain("fresh", -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
